// File: rtl/sequencer_step_input.sv
// sequencer_step_input: builds the 8-step pattern fed to the loop controller.
// Eight raw buttons are synchronised and debounced. Each debounced press toggles
// one step bit. A bus write strobe can overwrite the whole pattern.
// Optional feature macro: STEP_LONGPRESS_CLEAR_EN. When it is defined, holding
// button 0 for LONG_CYCLES clears the pattern once per hold.
module sequencer_step_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DB_W            = 20,
  parameter int unsigned LONG_CYCLES     = 100000000,
  parameter int unsigned LONG_W          = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btn_in,
  input  logic       sel,
  input  logic [7:0] data_in,
  output logic [7:0] pattern_out,
  output logic [7:0] press_evt,
  output logic       pattern_chg
);

  logic [7:0]      sync1;
  logic [7:0]      sync2;
  logic [7:0]      stable;
  logic [DB_W-1:0] cnt [8];
  logic [7:0]      commit;
  logic [7:0]      rise;
  logic            lp_clear;

  // Two-flop synchroniser per button
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // A bit commits when it has differed from stable for DEBOUNCE_CYCLES samples
  always_comb begin
    commit = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      commit[i] = (sync2[i] != stable[i]) &&
                  (cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1));
    end
    rise = commit & sync2;
  end

  // Per-bit debounce counters and accepted levels
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (commit[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef STEP_LONGPRESS_CLEAR_EN
  logic [LONG_W-1:0] lp_cnt;
  logic              lp_fired;

  // Clear fires on the first edge that sees the counter at its terminal value
  always_comb begin
    lp_clear = stable[0] && !lp_fired && (lp_cnt == LONG_W'(LONG_CYCLES - 1));
  end

  // Long-press counter on step 0; saturates, and lp_fired limits clear to once per hold
  always_ff @(posedge clk) begin
    if (rst || !stable[0]) begin
      lp_cnt   <= '0;
      lp_fired <= 1'b0;
    end else begin
      if (lp_cnt != LONG_W'(LONG_CYCLES - 1)) begin
        lp_cnt <= lp_cnt + 1'b1;
      end
      if (lp_clear) begin
        lp_fired <= 1'b1;
      end
    end
  end
`else
  logic unused_long;

  // Long-press clear is not built in this configuration
  always_comb begin
    lp_clear    = 1'b0;
    unused_long = (LONG_CYCLES == 0) ^ (LONG_W == 0);
  end
`endif

  // Pattern register: bus write beats long-press clear, which beats button toggles
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_out <= '0;
      press_evt   <= '0;
      pattern_chg <= 1'b0;
    end else begin
      press_evt <= rise;
      if (sel) begin
        pattern_out <= data_in;
        pattern_chg <= 1'b1;
      end else if (lp_clear) begin
        pattern_out <= '0;
        pattern_chg <= 1'b1;
      end else begin
        pattern_out <= pattern_out ^ rise;
        pattern_chg <= |rise;
      end
    end
  end

endmodule

// File: tb/tb_sequencer_step_input.sv
// Directed, table-driven bench for sequencer_step_input (DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
// Each table row drives inputs for one clock edge, then compares outputs just after it.
module tb_sequencer_step_input;

  logic       clk;
  logic       rst;
  logic [7:0] btn_in;
  logic       sel;
  logic [7:0] data_in;
  logic [7:0] pattern_out;
  logic [7:0] press_evt;
  logic       pattern_chg;

  int passed = 0;
  int total  = 0;

`ifdef STEP_LONGPRESS_CLEAR_EN
  localparam logic [7:0] LPV = 8'h00;
  localparam logic       LPC = 1'b1;
`else
  localparam logic [7:0] LPV = 8'h3D;
  localparam logic       LPC = 1'b0;
`endif

  typedef struct {
    logic       r;
    logic [7:0] b;
    logic       s;
    logic [7:0] d;
    logic [7:0] p;
    logic [7:0] pe;
    logic       c;
  } vec_t;

  vec_t vecs[$];

  sequencer_step_input #(
    .DEBOUNCE_CYCLES(4),
    .DB_W(3),
    .LONG_CYCLES(20),
    .LONG_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .sel(sel),
    .data_in(data_in),
    .pattern_out(pattern_out),
    .press_evt(press_evt),
    .pattern_chg(pattern_chg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic add(input int n, input logic r, input logic [7:0] b, input logic s,
                     input logic [7:0] d, input logic [7:0] p, input logic [7:0] pe,
                     input logic c);
    vec_t v;
    v.r = r; v.b = b; v.s = s; v.d = d; v.p = p; v.pe = pe; v.c = c;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s row %0d: got %02h expected %02h", name, idx, act, exp);
  endtask

  initial begin
    logic [7:0] cur;
    int         found;
    rst = 1'b1; btn_in = '0; sel = 1'b0; data_in = '0;

    // reset and single press on bit 0, then release
    add(1, 1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(5, 0, 8'h01, 0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 8'h01, 0, 8'h00, 8'h01, 8'h01, 1);
    add(4, 0, 8'h01, 0, 8'h00, 8'h01, 8'h00, 0);
    add(7, 0, 8'h00, 0, 8'h00, 8'h01, 8'h00, 0);
    // bouncing bit 3
    add(1, 0, 8'h08, 0, 8'h00, 8'h01, 8'h00, 0);
    add(1, 0, 8'h00, 0, 8'h00, 8'h01, 8'h00, 0);
    add(1, 0, 8'h08, 0, 8'h00, 8'h01, 8'h00, 0);
    add(1, 0, 8'h00, 0, 8'h00, 8'h01, 8'h00, 0);
    add(5, 0, 8'h08, 0, 8'h00, 8'h01, 8'h00, 0);
    add(1, 0, 8'h08, 0, 8'h00, 8'h09, 8'h08, 1);
    add(1, 0, 8'h08, 0, 8'h00, 8'h09, 8'h00, 0);
    add(7, 0, 8'h00, 0, 8'h00, 8'h09, 8'h00, 0);
    // write 80, then press bits 7 and 0 together
    add(1, 0, 8'h00, 1, 8'h80, 8'h80, 8'h00, 1);
    add(5, 0, 8'h81, 0, 8'h00, 8'h80, 8'h00, 0);
    add(1, 0, 8'h81, 0, 8'h00, 8'h01, 8'h81, 1);
    add(1, 0, 8'h81, 0, 8'h00, 8'h01, 8'h00, 0);
    add(7, 0, 8'h00, 0, 8'h00, 8'h01, 8'h00, 0);
    // bus write on the same edge as bit 1 commit
    add(5, 0, 8'h02, 0, 8'h00, 8'h01, 8'h00, 0);
    add(1, 0, 8'h02, 1, 8'hA5, 8'hA5, 8'h02, 1);
    add(1, 0, 8'h02, 0, 8'h00, 8'hA5, 8'h00, 0);
    add(7, 0, 8'h00, 0, 8'h00, 8'hA5, 8'h00, 0);
    // reset mid-hold; held button re-commits after full latency
    add(5, 0, 8'h01, 0, 8'h00, 8'hA5, 8'h00, 0);
    add(1, 0, 8'h01, 0, 8'h00, 8'hA4, 8'h01, 1);
    add(1, 0, 8'h01, 0, 8'h00, 8'hA4, 8'h00, 0);
    add(1, 1, 8'h01, 0, 8'h00, 8'h00, 8'h00, 0);
    add(5, 0, 8'h01, 0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 8'h01, 0, 8'h00, 8'h01, 8'h01, 1);
    add(1, 0, 8'h01, 0, 8'h00, 8'h01, 8'h00, 0);
    add(7, 0, 8'h00, 0, 8'h00, 8'h01, 8'h00, 0);
    // long press on bit 0 (30 held samples)
    add(1, 0, 8'h00, 1, 8'h3C, 8'h3C, 8'h00, 1);
    add(5, 0, 8'h01, 0, 8'h00, 8'h3C, 8'h00, 0);
    add(1, 0, 8'h01, 0, 8'h00, 8'h3D, 8'h01, 1);
    add(19, 0, 8'h01, 0, 8'h00, 8'h3D, 8'h00, 0);
    add(1, 0, 8'h01, 0, 8'h00, LPV, 8'h00, LPC);
    add(4, 0, 8'h01, 0, 8'h00, LPV, 8'h00, 0);
    add(7, 0, 8'h00, 0, 8'h00, LPV, 8'h00, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].r; btn_in = vecs[i].b; sel = vecs[i].s; data_in = vecs[i].d;
      step();
      check("pattern_out", i, pattern_out, vecs[i].p);
      check("press_evt", i, press_evt, vecs[i].pe);
      check("pattern_chg", i, {7'd0, pattern_chg}, {7'd0, vecs[i].c});
    end

    // writing an identical value still pulses pattern_chg
    cur = LPV;
    sel = 1'b1; data_in = cur; btn_in = '0;
    step();
    sel = 1'b0;
    check("same_write_pattern", -1, pattern_out, cur);
    check("same_write_chg", -1, {7'd0, pattern_chg}, 8'h01);

    // bounded wait for a press on bit 4; expected on the sixth edge
    btn_in = 8'h10;
    found = 0;
    for (int n = 1; n <= 20 && found == 0; n++) begin
      step();
      if (press_evt != 8'h00) found = n;
    end
    check("bit4_latency", -1, 8'(found), 8'd6);
    check("bit4_press", -1, press_evt, 8'h10);
    check("bit4_pattern", -1, pattern_out, cur ^ 8'h10);
    btn_in = '0;
    step();
    check("bit4_press_end", -1, press_evt, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
